// File: rtl/clock_forward_pkg.sv
// Shared types and sizing helpers for the clock_forward transmitter.
package clock_forward_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // bit_cnt must hold 0..n.
  function automatic int bit_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Counter that runs 0..h-1; never narrower than one bit.
  function automatic int div_cnt_w(input int h);
    return (h <= 1) ? 1 : $clog2(h);
  endfunction

  // Even parity over a zero-extended word.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/clock_forward_div.sv
// Half-period divider: single-cycle rise/fall ticks every HALF_DIV enabled cycles.
module clock_forward_div
  import clock_forward_pkg::*;
#(
  parameter int HALF_DIV = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int            DW     = div_cnt_w(HALF_DIV);
  localparam logic [DW-1:0] DIV_TC = DW'(HALF_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          ph_q, ph_d;
  logic          tc;

  always_comb begin
    tc        = en && (div_cnt_q == DIV_TC);
    div_cnt_d = div_cnt_q;
    ph_d      = ph_q;
    if (clr) begin
      div_cnt_d = '0;
      ph_d      = 1'b0;
    end else if (en) begin
      if (tc) begin
        div_cnt_d = '0;
        ph_d      = ~ph_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // ph_q tracks the forwarded clock level, so the tick direction follows it.
  assign rise_tick = tc && !ph_q;
  assign fall_tick = tc &&  ph_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt_q <= '0;
      ph_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ph_q      <= ph_d;
    end
  end

endmodule

// File: rtl/clock_forward_tx.sv
// Source-synchronous serializer: forwarded ser_clk plus MSB-first ser_dat.
// Define PARITY_EN to append an even-parity bit after the LSB.
module clock_forward_tx
  import clock_forward_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HALF_DIV   = 2
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  ser_clk,
  output logic                  ser_dat,
  output logic                  busy
);

`ifdef PARITY_EN
  localparam int FRAME_W = DATA_WIDTH + 1;
`else
  localparam int FRAME_W = DATA_WIDTH;
`endif
  localparam int            BW     = bit_cnt_w(FRAME_W);
  localparam int            GW     = div_cnt_w(2 * HALF_DIV);
  localparam logic [BW-1:0] BIT_TC = BW'(FRAME_W - 1);
  localparam logic [GW-1:0] GAP_TC = GW'(2 * HALF_DIV - 1);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   sh_q, sh_d, frame;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 ser_clk_q, ser_clk_d;
  logic                 ser_dat_q, ser_dat_d;
  logic                 busy_q, busy_d;
  logic                 div_clr, rise_tick, fall_tick;

`ifdef PARITY_EN
  assign frame = {tx_data, even_parity(64'(tx_data))};
`else
  assign frame = tx_data;
`endif

  clock_forward_div #(.HALF_DIV(HALF_DIV)) u_div (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (state_q == SHIFT),
    .clr       (div_clr),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_ready_d = tx_ready_q;
    ser_clk_d  = ser_clk_q;
    ser_dat_d  = ser_dat_q;
    busy_d     = busy_q;
    div_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d    = SHIFT;
          sh_d       = frame;
          bit_cnt_d  = '0;
          ser_dat_d  = frame[FRAME_W-1];
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          div_clr    = 1'b1;
        end
      end
      SHIFT: begin
        if (rise_tick) begin
          ser_clk_d = 1'b1;
        end else if (fall_tick) begin
          ser_clk_d = 1'b0;
          if (bit_cnt_q == BIT_TC) begin
            ser_dat_d = 1'b0;
            gap_cnt_d = '0;
            state_d   = GAP;
            div_clr   = 1'b1;
          end else begin
            // Data moves on the falling edge so it is stable at the next rise.
            sh_d      = sh_q << 1;
            ser_dat_d = sh_d[FRAME_W-1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_TC) begin
          state_d    = IDLE;
          tx_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_ready_d = 1'b1;
        ser_clk_d  = 1'b0;
        ser_dat_d  = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_ready_q <= 1'b1;
      ser_clk_q  <= 1'b0;
      ser_dat_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_ready_q <= tx_ready_d;
      ser_clk_q  <= ser_clk_d;
      ser_dat_q  <= ser_dat_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign ser_clk  = ser_clk_q;
  assign ser_dat  = ser_dat_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_clock_forward_tx.sv
// Directed bench for clock_forward_tx; PARITY_EN builds run the parity case at HALF_DIV=1.
module tb_clock_forward_tx;

`ifdef PARITY_EN
  localparam int HD  = 1;
  localparam int NB  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int HD  = 2;
  localparam int NB  = 8;
  localparam bit PAR = 1'b0;
`endif
  localparam int FEND = 2 * HD * (NB + 1);

  logic       clk_in = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, ser_clk, ser_dat, busy;
  int         total = 0;
  int         fails = 0;
  int         cyc_cnt = 0;

  clock_forward_tx #(.DATA_WIDTH(8), .HALF_DIV(HD)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ser_clk  (ser_clk),
    .ser_dat  (ser_dat),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Caller drives tx_valid/tx_data with tx_ready high; next edge is E0.
  task automatic run_frame(input logic [7:0] d, input logic [7:0] d_after,
                           input bit keep_valid, input string tag, output int e0);
    logic [8:0] fr;
    logic       prev;
    int         nr;
    fr = PAR ? {d, ^d} : {1'b0, d};
    tick();
    e0 = cyc_cnt;
    chk({tag, "_e0_ready"}, tx_ready, 0);
    chk({tag, "_e0_busy"}, busy, 1);
    chk({tag, "_e0_dat"}, ser_dat, fr[NB-1]);
    chk({tag, "_e0_clk"}, ser_clk, 0);
    tx_data  = d_after;
    tx_valid = keep_valid;
    prev = 1'b0;
    nr   = 0;
    for (int c = 1; c <= FEND; c++) begin
      tick();
      if (ser_clk && !prev) begin
        chk($sformatf("%s_rise%0d_cyc", tag, nr), c, HD * (2 * nr + 1));
        if (nr < NB) chk($sformatf("%s_bit%0d", tag, nr), ser_dat, fr[NB-1-nr]);
        nr++;
      end
      prev = ser_clk;
      if (c == FEND - 1) chk({tag, "_ready_early"}, tx_ready, 0);
      if (c == FEND) begin
        chk({tag, "_ready_end"}, tx_ready, 1);
        chk({tag, "_busy_end"}, busy, 0);
      end
    end
    chk({tag, "_nrises"}, nr, NB);
  endtask

  initial begin
    int e0a, e0b, nr;
    logic prev;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    chk("por_ready", tx_ready, 1);
    chk("por_clk", ser_clk, 0);
    chk("por_dat", ser_dat, 0);
    chk("por_busy", busy, 0);
    reset = 1'b0;
    repeat (4) tick();

    // Reset held 3 cycles while idle.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("idle_rst_ready", tx_ready, 1);
    chk("idle_rst_clk", ser_clk, 0);
    chk("idle_rst_dat", ser_dat, 0);
    chk("idle_rst_busy", busy, 0);
    tick();

`ifdef PARITY_EN
    tx_data = 8'h07; tx_valid = 1'b1;
    run_frame(8'h07, 8'h00, 1'b0, "par07", e0a);
`else
    tx_data = 8'hA5; tx_valid = 1'b1;
    run_frame(8'hA5, 8'h00, 1'b0, "a5", e0a);
    tick();

    // Back-to-back with tx_valid held.
    tx_data = 8'h3C; tx_valid = 1'b1;
    run_frame(8'h3C, 8'hC3, 1'b1, "b2b0", e0a);
    run_frame(8'hC3, 8'h00, 1'b0, "b2b1", e0b);
    chk("b2b_period", e0b - e0a, FEND + 1);
    tick();

    // tx_data changes right after acceptance.
    tx_data = 8'h00; tx_valid = 1'b1;
    run_frame(8'h00, 8'hFF, 1'b0, "hold", e0a);
    tick();
`endif

    // Reset while ser_clk is high during bit 3.
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (HD * 7) tick();
    chk("mf_clk_high", ser_clk, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mf_clk", ser_clk, 0);
    chk("mf_dat", ser_dat, 0);
    chk("mf_ready", tx_ready, 1);
    chk("mf_busy", busy, 0);
    prev = 1'b0; nr = 0;
    repeat (40) begin
      tick();
      if (ser_clk && !prev) nr++;
      prev = ser_clk;
    end
    chk("mf_no_rises", nr, 0);

    // Reset and tx_valid together: no acceptance.
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    reset = 1'b0; tx_valid = 1'b0;
    chk("rv_ready", tx_ready, 1);
    chk("rv_busy", busy, 0);
    chk("rv_dat", ser_dat, 0);
    tick();
    chk("rv_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
